// File: rtl/pe_packetizer.sv
// rtl/pe_packetizer.sv - wraps PE result words into NoC packets and queues them
// Optional: define PE_PACKETIZER_PARITY_EN to store even parity in bit PKT_W-1.
module pe_packetizer #(
  parameter int PKT_W    = 32,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEST_LSB = 24,
  parameter int SEQ_W    = 4,
  parameter logic [ADDR_W-1:0] SRC_ADDR  = 3'b001,
  parameter logic [ADDR_W-1:0] DEST_BASE = 3'b100,
  parameter int MODE     = 0,
  parameter int NUM_DEST = 1,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PKT_W-1:0]           out_pkt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PKT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [ADDR_W-1:0] rr_idx;
  logic [ADDR_W-1:0] dest;
  logic [PKT_W-1:0]  pkt;
  logic              push;
  logic              pop;

  // in_ready looks only at count, so a full FIFO refuses a push even when popping
  assign in_ready  = rst_n && !flush && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_pkt   = mem[rd_ptr];
  assign dest      = DEST_BASE + rr_idx;

  always_comb begin
    pkt = '0;
    pkt[DATA_W-1:0]                   = in_data;
    pkt[DATA_W +: SEQ_W]              = seq_cnt;
    pkt[DEST_LSB +: ADDR_W]           = dest;
    pkt[DEST_LSB + ADDR_W +: ADDR_W]  = SRC_ADDR;
`ifdef PE_PACKETIZER_PARITY_EN
    pkt[PKT_W-1] = ^pkt[PKT_W-2:0];
`else
    pkt[PKT_W-1] = 1'b0;
`endif
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq_cnt <= '0;
      rr_idx  <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= ptr_next(wr_ptr);
        seq_cnt <= seq_cnt + SEQ_W'(1);
        if (MODE == 1) begin
          rr_idx <= (rr_idx == ADDR_W'(NUM_DEST - 1)) ? '0 : rr_idx + ADDR_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_packetizer.sv
// tb/tb_pe_packetizer.sv - scoreboard bench for pe_packetizer (MODE 1, NUM_DEST 3)
module tb_pe_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pkt;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] expq [$];
  int          m_seq;
  int          m_rr;

  pe_packetizer #(
    .PKT_W(32), .DATA_W(8), .ADDR_W(3), .DEST_LSB(24), .SEQ_W(4),
    .SRC_ADDR(3'b001), .DEST_BASE(3'b100), .MODE(1), .NUM_DEST(3), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] make_pkt(input logic [7:0] d, input int seq, input int dst);
    logic [31:0] p;
    p = 32'h0;
    p[7:0]   = d;
    p[11:8]  = 4'(seq);
    p[26:24] = 3'(dst);
    p[29:27] = 3'b001;
`ifdef PE_PACKETIZER_PARITY_EN
    p[31] = ^p[30:0];
`endif
    return p;
  endfunction

  // scoreboard monitor: a pop happens at the next edge whenever valid&&ready here
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_pkt", out_pkt, 32'hxxxxxxxx);
      end else begin
        check("scoreboard_pkt", out_pkt, expq.pop_front());
      end
    end
  end

  task automatic model_clear();
    expq.delete();
    m_seq = 0;
    m_rr  = 0;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      expq.push_back(make_pkt(d, m_seq, 4 + m_rr));
      m_seq = (m_seq + 1) % 16;
      m_rr  = (m_rr + 1) % 3;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (count != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_count", 32'(count), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // single packet: src 1, dest 4, seq 0
    out_ready = 1'b1;
    send(8'hA5);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pkt", out_pkt, 32'h0C0000A5);
    @(posedge clk); #1;
    check("first_count_zero", 32'(count), 32'd0);

    // round robin: dest 4,5,6,4,5 with seq 0..4
    do_flush();
    for (int i = 0; i < 5; i++) begin
      send(8'h20 + 8'(i));
      check("rr_head_dest", 32'(out_pkt[26:24]), (i % 3 == 0) ? 32'd4 : (i % 3 == 1) ? 32'd5 : 32'd6);
    end
    drain();

    // back-pressure: fill, then full with simultaneous pop
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h14;
    repeat (2) @(posedge clk);
    #1;
    check("full_hold_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("full_pop_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    send(8'h14);
    send(8'h15);
    drain();

    // sequence wrap over 18 back-to-back accepts
    do_flush();
    for (int i = 0; i < 18; i++) begin
      send(8'h40 + 8'(i));
      check("stream_count", 32'(count), 32'd1);
      if (i == 15) check("seq_15", 32'(out_pkt[11:8]), 32'd15);
      if (i == 16) check("seq_wrap", 32'(out_pkt[11:8]), 32'd0);
    end
    drain();

    // flush with two packets queued
    do_flush();
    out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    check("pre_flush_count", 32'(count), 32'd2);
    do_flush();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    send(8'h3C);
    check("post_flush_pkt", out_pkt, 32'h0C00003C);
    drain();

    // reset mid-stream behaves like flush
    out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    check("reset_out_valid2", 32'(out_valid), 32'd0);
    check("reset_count2", 32'(count), 32'd0);
    out_ready = 1'b1;
    send(8'h3C);
    check("post_reset_pkt", out_pkt, 32'h0C00003C);
    drain();

    @(posedge clk); #1;
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
